// File: rtl/present_pkg.sv
// Shared widths, frame lengths and FSM state type for the PRESENT-80 input staging path.
package present_pkg;
   localparam int WORD_W    = 16;
   localparam int KEY_W     = 80;
   localparam int BLK_W     = 64;
   localparam int KEY_WORDS = KEY_W / WORD_W;
   localparam int DAT_WORDS = BLK_W / WORD_W;
   localparam int CNT_W     = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      KEY  = 2'd1,
      DAT  = 2'd2,
      HOLD = 2'd3
   } state_t;
endpackage

// File: rtl/present_word_acc.sv
// MSW-first shift accumulator: each shifted word enters at the bottom, older words move up.
module present_word_acc #(
   parameter int WORD_W = 16,
   parameter int WORDS  = 4,
   parameter int W      = WORDS * WORD_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              shift,
   input  logic [WORD_W-1:0] word,
   output logic [W-1:0]      value,
   output logic [W-1:0]      value_next
);
   logic [WORD_W-1:0] slot_reg [WORDS];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < WORDS; i++) slot_reg[i] <= '0;
      end else if (shift) begin
         for (int i = WORDS - 1; i > 0; i--) slot_reg[i] <= slot_reg[i-1];
         slot_reg[0] <= word;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < WORDS; gi++) begin : g_pack
         assign value[gi*WORD_W +: WORD_W] = slot_reg[gi];
      end
   endgenerate

   // Value as it will read after this cycle's shift, so a frame can complete on its last word.
   assign value_next = {value[W-WORD_W-1:0], word};
endmodule

// File: rtl/present_block_loader.sv
// Collects 16-bit key/data words into {key, plaintext} pairs for the PRESENT-80 round pipeline.
module present_block_loader
   import present_pkg::*;
#(
   parameter int WORD_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_word,
   input  logic              in_is_key,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [KEY_W-1:0]  out_key,
   output logic [BLK_W-1:0]  out_dat,
   output logic              key_valid,
   output logic              err
);
   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             drop_reg;
   logic [KEY_W-1:0] key_reg;
   logic [KEY_W-1:0] out_key_reg;
   logic [BLK_W-1:0] out_dat_reg;
   logic             out_valid_reg;
   logic             key_valid_reg;
   logic             err_reg;

   logic             accept;
   logic             out_xfer;
   logic             key_shift;
   logic             dat_shift;
   logic [KEY_W-1:0] key_stage;
   logic [KEY_W-1:0] key_stage_next;
   logic [BLK_W-1:0] dat_stage;
   logic [BLK_W-1:0] dat_stage_next;

   assign in_ready  = (state_reg != HOLD);
   assign accept    = in_valid && in_ready;
   assign out_xfer  = out_valid_reg && out_ready;
   assign key_shift = accept && in_is_key && (state_reg != DAT);
   assign dat_shift = accept && !in_is_key && (state_reg != KEY);

   present_word_acc #(.WORD_W(WORD_W), .WORDS(KEY_WORDS), .W(KEY_W)) u_key_acc (
      .clk        (clk),
      .reset      (reset),
      .shift      (key_shift),
      .word       (in_word),
      .value      (key_stage),
      .value_next (key_stage_next)
   );

   present_word_acc #(.WORD_W(WORD_W), .WORDS(DAT_WORDS), .W(BLK_W)) u_dat_acc (
      .clk        (clk),
      .reset      (reset),
      .shift      (dat_shift),
      .word       (in_word),
      .value      (dat_stage),
      .value_next (dat_stage_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         drop_reg      <= 1'b0;
         key_reg       <= '0;
         out_key_reg   <= '0;
         out_dat_reg   <= '0;
         out_valid_reg <= 1'b0;
         key_valid_reg <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         err_reg <= 1'b0;
         // A slot reload further down overrides this drain.
         if (out_xfer) out_valid_reg <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (accept) begin
                  cnt_reg <= CNT_W'(1);
                  if (in_is_key) begin
                     state_reg <= KEY;
                  end else begin
                     state_reg <= DAT;
                     drop_reg  <= !key_valid_reg;
                     err_reg   <= !key_valid_reg;
                  end
               end
            end
            KEY: begin
               if (accept) begin
                  if (!in_is_key) begin
                     err_reg   <= 1'b1;
                     state_reg <= IDLE;
                     cnt_reg   <= '0;
                  end else if (cnt_reg == CNT_W'(KEY_WORDS - 1)) begin
                     key_reg       <= key_stage_next;
                     key_valid_reg <= 1'b1;
                     state_reg     <= IDLE;
                     cnt_reg       <= '0;
                  end else begin
                     cnt_reg <= cnt_reg + CNT_W'(1);
                  end
               end
            end
            DAT: begin
               if (accept) begin
                  if (in_is_key) begin
                     err_reg   <= 1'b1;
                     state_reg <= IDLE;
                     cnt_reg   <= '0;
                     drop_reg  <= 1'b0;
                  end else if (cnt_reg == CNT_W'(DAT_WORDS - 1)) begin
                     cnt_reg  <= '0;
                     drop_reg <= 1'b0;
                     if (drop_reg) begin
                        state_reg <= IDLE;
                     end else if (!out_valid_reg || out_ready) begin
                        out_dat_reg   <= dat_stage_next;
                        out_key_reg   <= key_reg;
                        out_valid_reg <= 1'b1;
                        state_reg     <= IDLE;
                     end else begin
                        state_reg <= HOLD;
                     end
                  end else begin
                     cnt_reg <= cnt_reg + CNT_W'(1);
                  end
               end
            end
            HOLD: begin
               // No key word can be accepted here, so key_reg is still the completion-time key.
               if (out_ready) begin
                  out_dat_reg   <= dat_stage;
                  out_key_reg   <= key_reg;
                  out_valid_reg <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign out_valid = out_valid_reg;
   assign out_key   = out_key_reg;
   assign out_dat   = out_dat_reg;
   assign key_valid = key_valid_reg;
   assign err       = err_reg;
endmodule

// File: tb/tb_present_block_loader.sv
// Bench for present_block_loader: per-cycle vector table, directed backpressure/reload/reset
// sequences, then random traffic scored against a frame-level reference model.
module tb_present_block_loader;
   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_word;
   logic        in_is_key;
   logic        out_valid;
   logic        out_ready;
   logic [79:0] out_key;
   logic [63:0] out_dat;
   logic        key_valid;
   logic        err;

   int n_pass  = 0;
   int n_total = 0;

   localparam logic [79:0] K1 = 80'h0123_4567_89AB_CDEF_0F1E;
   localparam logic [63:0] D1 = 64'hDEAD_BEEF_CAFE_F00D;
   localparam logic [63:0] D2 = 64'h1111_2222_3333_4444;
   localparam logic [63:0] DA = 64'hA0A0_A1A1_A2A2_A3A3;
   localparam logic [63:0] DB = 64'hB0B0_B1B1_B2B2_B3B3;

   present_block_loader #(.WORD_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_word   (in_word),
      .in_is_key (in_is_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_key   (out_key),
      .out_dat   (out_dat),
      .key_valid (key_valid),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string name, input logic act, input logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0b, expected %0b", name, act, exp);
   endtask

   task automatic chk_k(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic chk_d(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic k, input logic [15:0] w);
      in_valid  = v;
      in_is_key = k;
      in_word   = w;
   endtask

   task automatic send_frame(input logic k, input logic [79:0] val, input int nw);
      for (int i = 0; i < nw; i++) begin
         drive(1'b1, k, val[(nw-1-i)*16 +: 16]);
         cycle();
      end
      drive(1'b0, 1'b0, 16'h0);
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, 1'b0, 16'h0);
      cycle();
      reset = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct packed {
      logic        rst;
      logic        vld;
      logic        is_key;
      logic        ordy;
      logic [15:0] word;
      logic        e_rdy;
      logic        e_ovld;
      logic        e_kvld;
      logic        e_err;
      logic [79:0] e_key;
      logic [63:0] e_dat;
   } vec_t;

   vec_t vecs[24];

   function automatic vec_t mk(input logic rst, input logic vld, input logic k, input logic ordy,
                               input logic [15:0] w, input logic e_rdy, input logic e_ovld,
                               input logic e_kvld, input logic e_err,
                               input logic [79:0] e_key, input logic [63:0] e_dat);
      vec_t v;
      v.rst = rst;     v.vld = vld;       v.is_key = k;      v.ordy = ordy;
      v.word = w;      v.e_rdy = e_rdy;   v.e_ovld = e_ovld;
      v.e_kvld = e_kvld; v.e_err = e_err; v.e_key = e_key;  v.e_dat = e_dat;
      return v;
   endfunction

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [79:0] key;
      logic [63:0] dat;
   } pair_t;

   pair_t       mq[$];
   logic [79:0] m_key;
   bit          m_kvld;
   bit          m_err;
   int          fr_len;
   bit          fr_key;
   bit          fr_drop;
   logic [79:0] fr_val;

   task automatic model_reset();
      mq.delete();
      m_key  = '0;
      m_kvld = 1'b0;
      m_err  = 1'b0;
      fr_len = 0;
   endtask

   task automatic model_word(input bit k, input logic [15:0] w);
      if (fr_len == 0) begin
         fr_key  = k;
         fr_drop = !k && !m_kvld;
         m_err   = fr_drop;
         fr_val  = {64'h0, w};
         fr_len  = 1;
      end else if (k != fr_key) begin
         m_err  = 1'b1;
         fr_len = 0;
      end else begin
         fr_val = (fr_val << 16) | {64'h0, w};
         fr_len++;
         if (fr_key && fr_len == 5) begin
            m_key  = fr_val;
            m_kvld = 1'b1;
            fr_len = 0;
         end else if (!fr_key && fr_len == 4) begin
            if (!fr_drop) mq.push_back('{key: m_key, dat: fr_val[63:0]});
            fr_len = 0;
         end
      end
   endtask

   initial begin
      bit          r_rst;
      bit          r_vld;
      bit          r_k;
      bit          r_ordy;
      bit          acc;
      bit          xfer;
      logic [15:0] r_w;
      pair_t       front;

      reset     = 1'b1;
      out_ready = 1'b0;
      drive(1'b0, 1'b0, 16'h0);
      @(negedge clk);

      // Data-before-key, key load, data block, mid-frame tag flip, stall.
      vecs[0]  = mk(1, 0, 0, 1, 16'h0000, 1, 0, 0, 0, '0, '0);
      vecs[1]  = mk(0, 1, 0, 1, 16'hAAAA, 1, 0, 0, 1, '0, '0);
      vecs[2]  = mk(0, 1, 0, 1, 16'hAAAB, 1, 0, 0, 0, '0, '0);
      vecs[3]  = mk(0, 1, 0, 1, 16'hAAAC, 1, 0, 0, 0, '0, '0);
      vecs[4]  = mk(0, 1, 0, 1, 16'hAAAD, 1, 0, 0, 0, '0, '0);
      vecs[5]  = mk(0, 1, 1, 1, 16'h0123, 1, 0, 0, 0, '0, '0);
      vecs[6]  = mk(0, 1, 1, 1, 16'h4567, 1, 0, 0, 0, '0, '0);
      vecs[7]  = mk(0, 1, 1, 1, 16'h89AB, 1, 0, 0, 0, '0, '0);
      vecs[8]  = mk(0, 1, 1, 1, 16'hCDEF, 1, 0, 0, 0, '0, '0);
      vecs[9]  = mk(0, 1, 1, 1, 16'h0F1E, 1, 0, 1, 0, '0, '0);
      vecs[10] = mk(0, 1, 0, 1, 16'hDEAD, 1, 0, 1, 0, '0, '0);
      vecs[11] = mk(0, 1, 0, 1, 16'hBEEF, 1, 0, 1, 0, '0, '0);
      vecs[12] = mk(0, 1, 0, 1, 16'hCAFE, 1, 0, 1, 0, '0, '0);
      vecs[13] = mk(0, 1, 0, 1, 16'hF00D, 1, 1, 1, 0, K1, D1);
      vecs[14] = mk(0, 0, 0, 1, 16'h0000, 1, 0, 1, 0, '0, '0);
      vecs[15] = mk(0, 1, 1, 1, 16'hFFFF, 1, 0, 1, 0, '0, '0);
      vecs[16] = mk(0, 1, 1, 1, 16'hFFFE, 1, 0, 1, 0, '0, '0);
      vecs[17] = mk(0, 1, 0, 1, 16'h1234, 1, 0, 1, 1, '0, '0);
      vecs[18] = mk(0, 1, 0, 1, 16'h1111, 1, 0, 1, 0, '0, '0);
      vecs[19] = mk(0, 1, 0, 1, 16'h2222, 1, 0, 1, 0, '0, '0);
      vecs[20] = mk(0, 1, 0, 1, 16'h3333, 1, 0, 1, 0, '0, '0);
      vecs[21] = mk(0, 1, 0, 1, 16'h4444, 1, 1, 1, 0, K1, D2);
      vecs[22] = mk(0, 0, 0, 0, 16'h0000, 1, 1, 1, 0, K1, D2);
      vecs[23] = mk(0, 0, 0, 1, 16'h0000, 1, 0, 1, 0, '0, '0);

      for (int i = 0; i < 24; i++) begin
         reset     = vecs[i].rst;
         out_ready = vecs[i].ordy;
         drive(vecs[i].vld, vecs[i].is_key, vecs[i].word);
         cycle();
         chk1($sformatf("vec%0d in_ready", i), in_ready, vecs[i].e_rdy);
         chk1($sformatf("vec%0d out_valid", i), out_valid, vecs[i].e_ovld);
         chk1($sformatf("vec%0d key_valid", i), key_valid, vecs[i].e_kvld);
         chk1($sformatf("vec%0d err", i), err, vecs[i].e_err);
         if (vecs[i].e_ovld) begin
            chk_k($sformatf("vec%0d out_key", i), out_key, vecs[i].e_key);
            chk_d($sformatf("vec%0d out_dat", i), out_dat, vecs[i].e_dat);
         end
      end
      reset = 1'b0;
      drive(1'b0, 1'b0, 16'h0);

      // Basic all-zero load with exact latency.
      do_reset();
      chk_k("zero reset out_key", out_key, '0);
      chk_d("zero reset out_dat", out_dat, '0);
      for (int i = 0; i < 5; i++) begin
         chk1($sformatf("zero key_valid before word%0d", i), key_valid, 1'b0);
         drive(1'b1, 1'b1, 16'h0);
         cycle();
      end
      chk1("zero key_valid after word 5", key_valid, 1'b1);
      for (int i = 0; i < 4; i++) begin
         chk1($sformatf("zero out_valid before dword%0d", i), out_valid, 1'b0);
         drive(1'b1, 1'b0, 16'h0);
         cycle();
      end
      drive(1'b0, 1'b0, 16'h0);
      chk1("zero out_valid", out_valid, 1'b1);
      chk_k("zero out_key", out_key, '0);
      chk_d("zero out_dat", out_dat, '0);

      // Backpressure plus key reload while a pair waits in the slot.
      do_reset();
      send_frame(1'b1, '1, 5);
      out_ready = 1'b0;
      send_frame(1'b0, {16'h0, DA}, 4);
      chk1("bp A out_valid", out_valid, 1'b1);
      chk_k("bp A out_key", out_key, '1);
      chk_d("bp A out_dat", out_dat, DA);
      send_frame(1'b1, '0, 5);
      chk_k("bp A key kept after reload", out_key, '1);
      send_frame(1'b0, {16'h0, DB}, 4);
      chk1("bp hold in_ready", in_ready, 1'b0);
      for (int i = 0; i < 3; i++) cycle();
      chk1("bp stall out_valid", out_valid, 1'b1);
      chk_d("bp stall out_dat", out_dat, DA);
      chk_k("bp stall out_key", out_key, '1);
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      chk1("bp B out_valid no gap", out_valid, 1'b1);
      chk_d("bp B out_dat", out_dat, DB);
      chk_k("bp B out_key", out_key, '0);
      chk1("bp B in_ready", in_ready, 1'b1);
      out_ready = 1'b1;
      cycle();
      chk1("bp drained out_valid", out_valid, 1'b0);

      // Reset while in HOLD.
      do_reset();
      send_frame(1'b1, K1, 5);
      out_ready = 1'b0;
      send_frame(1'b0, {16'h0, D1}, 4);
      send_frame(1'b0, {16'h0, D2}, 4);
      chk1("rsthold in_ready before", in_ready, 1'b0);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk1("rsthold out_valid", out_valid, 1'b0);
      chk1("rsthold key_valid", key_valid, 1'b0);
      chk1("rsthold in_ready", in_ready, 1'b1);
      chk1("rsthold err", err, 1'b0);

      // Random traffic against the frame-level model.
      do_reset();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         chk1("rnd in_ready", in_ready, mq.size() < 2);
         chk1("rnd out_valid", out_valid, mq.size() > 0);
         chk1("rnd key_valid", key_valid, m_kvld);
         chk1("rnd err", err, m_err);
         if (mq.size() > 0) begin
            front = mq[0];
            chk_k("rnd out_key", out_key, front.key);
            chk_d("rnd out_dat", out_dat, front.dat);
         end
         r_rst  = ($urandom_range(0, 499) == 0);
         r_vld  = ($urandom_range(0, 3) != 0);
         r_ordy = ($urandom_range(0, 1) == 1);
         r_w    = 16'($urandom);
         if (fr_len == 0) r_k = ($urandom_range(0, 2) == 0);
         else r_k = ($urandom_range(0, 19) == 0) ? !fr_key : fr_key;
         reset     = r_rst;
         out_ready = r_ordy;
         drive(r_vld, r_k, r_w);
         acc  = !r_rst && r_vld && (mq.size() < 2);
         xfer = !r_rst && r_ordy && (mq.size() > 0);
         cycle();
         m_err = 1'b0;
         if (r_rst) begin
            model_reset();
         end else begin
            if (xfer) void'(mq.pop_front());
            if (acc) model_word(r_k, r_w);
         end
      end
      reset = 1'b0;
      drive(1'b0, 1'b0, 16'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
